arm_alu_shifter: RTL and testbench
==================================

# arm_alu_shifter

Combined ARM7TDMI-style execute datapath: a 32-bit barrel shifter feeding operand B of a 32-bit data-processing ALU. It sits in the CPU core between the register-file read buses and the writeback/address logic. Operand A arrives on the A bus and the raw operand B on the B bus. The block returns a 32-bit result and next-state NZCV flags. Two small internal latches support multi-cycle register-specified shifts and a held operand B.

## Interface
- No parameters.
- clk  in  1  clock; all latches update on rising edge.
- reset  in  1  synchronous, active-high; clears internal latches.
- op_a  in  32  ALU operand A (A bus).
- r_in  in  32  shifter input (B bus).
- alu_op  in  4  ARM data-processing opcode (AND=0 … MVN=15).
- flags_in  in  4  current {N,Z,C,V}.
- latch_op_b  in  1  capture shifter output into the op-B latch at the clock edge.
- use_op_b_latch  in  1  ALU operand B taken from the op-B latch.
- disable_op_b  in  1  ALU operand B forced to 0; overrides use_op_b_latch.
- shift_type  in  2  0 LSL, 1 LSR, 2 ASR, 3 ROR.
- shift_amount  in  5  immediate shift amount.
- shift_latch_amt  in  1  capture r_in[7:0] into the shift-amount latch.
- shift_use_latch  in  1  use the latched 8-bit amount (register-shift rules) instead of shift_amount (immediate rules).
- shift_use_rxx  in  1  with ROR and immediate amount 0, perform RRX.
- carry_in  in  1  CPSR.C for the shifter.
- result  out  32  ALU result (combinational).
- flags_out  out  4  computed {N,Z,C,V} (combinational).
- shift_out  out  32, shift_carry  out  1  shifter result and carry (combinational).

## Operation
- Immediate shift rules (shift_use_latch=0, amount n):
  - LSL #0: pass-through, C=carry_in.
  - LSR #0 and ASR #0: treated as #32.
  - ROR #0: RRX if shift_use_rxx = {carry_in, r_in[31:1]} with C=r_in[0]; otherwise pass-through with C=carry_in.
  - Any other n: standard shift; C = last bit shifted out.
- Register shift rules (latched amount a, 0..255):
  - a=0: pass-through, C=carry_in, for every type.
  - LSL: a=32 gives 0 with C=bit0; a>32 gives 0 with C=0.
  - LSR: a=32 gives 0 with C=bit31; a>32 gives 0 with C=0.
  - ASR: a≥32 fills every bit with bit31 and C=bit31.
  - ROR: a[4:0]=0 with a≠0 gives pass-through with C=bit31; otherwise rotate by a[4:0].
- Operand B: 0 if disable_op_b; else the op-B latch if use_op_b_latch; else shift_out.
- ALU ops, with B the selected operand B:
  - AND, EOR, SUB (A−B), RSB (B−A), ADD, ADC, SBC (A−B−!C), RSC.
  - TST, TEQ, CMP, CMN.
  - ORR, MOV (B), BIC (A&~B), MVN (~B).
  - Test ops (TST/TEQ/CMP/CMN) still drive the computed value on result.
- Flags:
  - N = result[31]; Z = (result==0).
  - Logical ops: C = shift_carry, or flags_in.C when disable_op_b/use_op_b_latch is set; V = flags_in.V.
  - Arithmetic ops: C = carry out of the 33-bit add, where subtraction gives C = NOT borrow; V = signed overflow.
  - ADC/SBC/RSC use flags_in.C.

## Timing
- result, flags_out, shift_out and shift_carry are purely combinational from the current inputs and latch contents. Zero-cycle latency.
- Latches load at the rising edge when their enable is set and are read in later cycles:
  - shift-amount latch ← r_in[7:0]
  - op-B latch ← shift_out
- Register-shift sequence: cycle 1 has Rs on r_in with shift_latch_amt=1. Cycle 2 has Rm on r_in with shift_use_latch=1; the result is valid in cycle 2.
- Latch enable and latch use in the same cycle: the use sees the old value.
- Reset clears both latches to 0; combinational outputs follow the inputs during reset.

## Structure
- Shared package: alu_op_t (4-bit enum of the 16 opcodes), shift_type_t, flags_t {n,z,c,v}.
- One sub-module, barrel_shift_core. It is combinational and takes value, amount[7:0], type, an imm/reg mode flag, rrx and carry_in, and returns value and carry.
- The top level holds both latches, the operand-B mux, the adder and the flag logic.

## Test plan
- LSL imm #4, r_in=0x8000_000F, MOV → result 0x0000_00F0, C=0, N=0, Z=0.
- ROR imm #0, shift_use_rxx=1, carry_in=1, r_in=0x0000_0003 → shift_out 0x8000_0001, C=1.
- Register LSR with Rs=0x120 (a=32) latched, then Rm=0x8000_0000 → shift_out 0, C=1. Repeat with a=33 → C=0.
- SUB A=5, B=7 → result 0xFFFF_FFFE, N=1, Z=0, C=0, V=0. CMP A=7, B=7 → Z=1, C=1.
- ADD 0x7FFF_FFFF+1 → 0x8000_0000, V=1, N=1. ADC 0xFFFF_FFFF+0 with C=1 → 0, Z=1, C=1.
- Latch: cycle 1 latch_op_b with shift_out=0x1234. Cycle 2 use_op_b_latch, ORR with A=0x0001 → 0x1235. Reset mid-sequence → latch 0, result 0x0001.

Source files
------------

// File: rtl/arm_alu_shifter_pkg.sv
// rtl/arm_alu_shifter_pkg.sv - shared types for the ARM execute datapath
// Purpose: opcode, shift-type and flag types plus the logical-op classifier
// shared by the barrel shifter core and the ALU top level.
package arm_alu_shifter_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
    OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
    OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
    OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_type_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Logical ops take C from the shifter and leave V untouched.
  function automatic logic is_logical(alu_op_t op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: is_logical = 1'b1;
      default:                        is_logical = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_alu_shifter_barrel_shift_core.sv
// rtl/arm_alu_shifter_barrel_shift_core.sv - combinational ARM barrel shifter
// Purpose: LSL/LSR/ASR/ROR/RRX with ARM immediate and register amount rules.
// Ports: value/amount/stype in, reg_mode selects register-amount rules,
//        rrx turns immediate ROR #0 into RRX, carry_in is CPSR.C;
//        result/carry out.
module barrel_shift_core
  import arm_alu_shifter_pkg::*;
(
  input  logic [31:0] value,
  input  logic [7:0]  amount,
  input  logic [1:0]  stype,
  input  logic        reg_mode,
  input  logic        rrx,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry
);

  shift_type_t        t;
  logic [5:0]         n;        // effective amount 0..32; 33 means "beyond 32"
  logic [5:0]         n_asr;
  logic [32:0]        lsl_tmp;
  logic [32:0]        lsr_tmp;
  logic signed [32:0] asr_tmp;
  logic [31:0]        ror_res;

  assign t     = shift_type_t'(stype);
  assign n_asr = (n == 6'd33) ? 6'd32 : n;

  // Normalise the amount: immediate LSR/ASR #0 encode #32, register amounts
  // above 32 collapse to one marker value, ROR only uses the low five bits.
  always_comb begin
    n = 6'd0;
    if (!reg_mode) begin
      n = {1'b0, amount[4:0]};
      if (amount[4:0] == 5'd0 && (t == SH_LSR || t == SH_ASR))
        n = 6'd32;
    end else if (t == SH_ROR) begin
      n = {1'b0, amount[4:0]};
    end else if (amount > 8'd32) begin
      n = 6'd33;
    end else begin
      n = amount[5:0];
    end
  end

  always_comb begin
    result  = value;
    carry   = carry_in;
    // An extra bit on the shifted-out side captures the last bit lost.
    lsl_tmp = {1'b0, value} << n;
    lsr_tmp = {value, 1'b0} >> n;
    asr_tmp = $signed({value, 1'b0}) >>> n_asr;
    ror_res = (value >> n) | (value << (6'd32 - n));
    if (n != 6'd0) begin
      case (t)
        SH_LSL:  {carry, result} = (n == 6'd33) ? 33'd0 : lsl_tmp;
        SH_LSR:  {result, carry} = (n == 6'd33) ? 33'd0 : lsr_tmp;
        SH_ASR:  {result, carry} = asr_tmp;
        default: begin
          result = ror_res;
          carry  = ror_res[31];
        end
      endcase
    end else if (t == SH_ROR) begin
      if (reg_mode && amount != 8'd0) begin
        carry = value[31];                 // rotate by a multiple of 32
      end else if (!reg_mode && rrx) begin
        result = {carry_in, value[31:1]};
        carry  = value[0];
      end
    end
  end

endmodule

// File: rtl/arm_alu_shifter.sv
// rtl/arm_alu_shifter.sv - ARM7TDMI-style shifter + data-processing ALU
// Purpose: barrel shifter feeding ALU operand B, with a shift-amount latch
// for register-specified shifts and an op-B latch for held operands.
// Ports: clk, reset (sync, active-high); op_a, r_in, alu_op, flags_in;
//        latch/operand-B controls; shift controls and carry_in;
//        result, flags_out, shift_out, shift_carry (all combinational).
module arm_alu_shifter
  import arm_alu_shifter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op_a,
  input  logic [31:0] r_in,
  input  logic [3:0]  alu_op,
  input  logic [3:0]  flags_in,
  input  logic        latch_op_b,
  input  logic        use_op_b_latch,
  input  logic        disable_op_b,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_amount,
  input  logic        shift_latch_amt,
  input  logic        shift_use_latch,
  input  logic        shift_use_rxx,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic [3:0]  flags_out,
  output logic [31:0] shift_out,
  output logic        shift_carry
);

  logic [7:0]  amt_latch;
  logic [31:0] op_b_latch;
  logic [7:0]  amt_sel;
  logic [31:0] op_b;
  alu_op_t     op;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_cin;
  logic [32:0] sum;
  logic        logical;
  flags_t      fl;
  logic        fin_c;
  logic        fin_v;
  logic        unused_flags;

  assign fin_c        = flags_in[1];
  assign fin_v        = flags_in[0];
  assign unused_flags = &{1'b0, flags_in[3:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      amt_latch  <= 8'd0;
      op_b_latch <= 32'd0;
    end else begin
      if (shift_latch_amt) amt_latch  <= r_in[7:0];
      if (latch_op_b)      op_b_latch <= shift_out;
    end
  end

  assign amt_sel = shift_use_latch ? amt_latch : {3'b000, shift_amount};

  barrel_shift_core u_shift (
    .value    (r_in),
    .amount   (amt_sel),
    .stype    (shift_type),
    .reg_mode (shift_use_latch),
    .rrx      (shift_use_rxx),
    .carry_in (carry_in),
    .result   (shift_out),
    .carry    (shift_carry)
  );

  assign op_b = disable_op_b   ? 32'd0 :
                use_op_b_latch ? op_b_latch : shift_out;

  assign op      = alu_op_t'(alu_op);
  assign logical = is_logical(op);

  // Every arithmetic op is one 33-bit add: subtraction inverts the
  // subtrahend, so bit 32 is NOT borrow.
  always_comb begin
    add_x   = op_a;
    add_y   = op_b;
    add_cin = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin add_y = ~op_b; add_cin = 1'b1; end
      OP_RSB:         begin add_x = op_b; add_y = ~op_a; add_cin = 1'b1; end
      OP_ADC:         add_cin = fin_c;
      OP_SBC:         begin add_y = ~op_b; add_cin = fin_c; end
      OP_RSC:         begin add_x = op_b; add_y = ~op_a; add_cin = fin_c; end
      default:        ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  always_comb begin
    case (op)
      OP_AND, OP_TST: result = op_a & op_b;
      OP_EOR, OP_TEQ: result = op_a ^ op_b;
      OP_ORR:         result = op_a | op_b;
      OP_MOV:         result = op_b;
      OP_BIC:         result = op_a & ~op_b;
      OP_MVN:         result = ~op_b;
      default:        result = sum[31:0];
    endcase
  end

  // With a latched or forced-zero operand the shifter carry is unrelated
  // to B, so logical ops keep the current C.
  always_comb begin
    fl.n = result[31];
    fl.z = (result == 32'd0);
    if (logical) begin
      fl.c = (disable_op_b || use_op_b_latch) ? fin_c : shift_carry;
      fl.v = fin_v;
    end else begin
      fl.c = sum[32];
      fl.v = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
    end
  end

  assign flags_out = fl;

endmodule

// File: tb/tb_arm_alu_shifter.sv
// tb/tb_arm_alu_shifter.sv - self-checking bench for arm_alu_shifter
module tb_arm_alu_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_a, r_in;
  logic [3:0]  alu_op, flags_in;
  logic        latch_op_b, use_op_b_latch, disable_op_b;
  logic [1:0]  shift_type;
  logic [4:0]  shift_amount;
  logic        shift_latch_amt, shift_use_latch, shift_use_rxx, carry_in;
  logic [31:0] result, shift_out;
  logic [3:0]  flags_out;
  logic        shift_carry;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arm_alu_shifter dut (
    .clk(clk), .reset(reset), .op_a(op_a), .r_in(r_in), .alu_op(alu_op),
    .flags_in(flags_in), .latch_op_b(latch_op_b), .use_op_b_latch(use_op_b_latch),
    .disable_op_b(disable_op_b), .shift_type(shift_type), .shift_amount(shift_amount),
    .shift_latch_amt(shift_latch_amt), .shift_use_latch(shift_use_latch),
    .shift_use_rxx(shift_use_rxx), .carry_in(carry_in), .result(result),
    .flags_out(flags_out), .shift_out(shift_out), .shift_carry(shift_carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference shifter: one bit per step, ARM amount rules applied first.
  function automatic logic [32:0] m_shift(input logic [31:0] v, input logic [7:0] amt,
                                          input logic [1:0] t, input logic regm,
                                          input logic rrx, input logic cin);
    int n;
    logic [31:0] r = v;
    logic c = cin;
    if (!regm) begin
      n = int'(amt[4:0]);
      if (n == 0) begin
        if (t == 2'd1 || t == 2'd2) n = 32;
        else if (t == 2'd3 && rrx) return {v[0], cin, v[31:1]};
      end
    end else begin
      n = int'(amt);
      if (t == 2'd3 && n != 0) begin
        n = n % 32;
        if (n == 0) return {v[31], v};
      end
    end
    for (int i = 0; i < n; i++) begin
      case (t)
        2'd0: begin c = r[31]; r = r << 1; end
        2'd1: begin c = r[0];  r = r >> 1; end
        2'd2: begin c = r[0];  r = {r[31], r[31:1]}; end
        default: begin c = r[0]; r = {r[0], r[31:1]}; end
      endcase
    end
    return {c, r};
  endfunction

  // Reference ALU in 64-bit integer arithmetic; returns {n,z,c,v,result}.
  function automatic logic [35:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op, input logic [3:0] fin,
                                        input logic keep_c, input logic shc);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ci = longint'(fin[1]);
    longint u = 0, s = 0;
    logic [31:0] r = 32'd0;
    logic logical = 1'b0, is_sub = 1'b1, c, v;
    case (op)
      4'd0, 4'd8:  begin r = a & b; logical = 1'b1; end
      4'd1, 4'd9:  begin r = a ^ b; logical = 1'b1; end
      4'd12:       begin r = a | b; logical = 1'b1; end
      4'd13:       begin r = b;     logical = 1'b1; end
      4'd14:       begin r = a & ~b; logical = 1'b1; end
      4'd15:       begin r = ~b;    logical = 1'b1; end
      4'd2, 4'd10: begin u = ua - ub; s = sa - sb; end
      4'd3:        begin u = ub - ua; s = sb - sa; end
      4'd4, 4'd11: begin u = ua + ub; s = sa + sb; is_sub = 1'b0; end
      4'd5:        begin u = ua + ub + ci; s = sa + sb + ci; is_sub = 1'b0; end
      4'd6:        begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); end
      default:     begin u = ub - ua - (1 - ci); s = sb - sa - (1 - ci); end
    endcase
    if (logical) begin
      c = keep_c ? fin[1] : shc;
      v = fin[0];
    end else begin
      r = u[31:0];
      c = is_sub ? (u >= 0) : (u >= (longint'(1) << 32));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  typedef struct {
    logic [31:0] a, rin;
    logic [3:0]  op, fin;
    logic [1:0]  st;
    logic [4:0]  amt;
    logic        rrx, cin;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
    logic [31:0] exp_sh;
    logic        exp_c;
  } vec_t;

  vec_t vecs[16];

  task automatic idle();
    reset = 1'b0; op_a = 32'd0; r_in = 32'd0; alu_op = 4'd13; flags_in = 4'd0;
    latch_op_b = 1'b0; use_op_b_latch = 1'b0; disable_op_b = 1'b0;
    shift_type = 2'd0; shift_amount = 5'd0; shift_latch_amt = 1'b0;
    shift_use_latch = 1'b0; shift_use_rxx = 1'b0; carry_in = 1'b0;
  endtask

  task automatic load_amt(input logic [31:0] v);
    @(negedge clk);
    r_in = v; shift_latch_amt = 1'b1; shift_use_latch = 1'b0;
    @(negedge clk);
    shift_latch_amt = 1'b0;
  endtask

  task automatic reg_shift(input string name, input logic [31:0] rs, input logic [1:0] t,
                           input logic [31:0] rm, input logic [31:0] exp_sh, input logic exp_c);
    load_amt(rs);
    r_in = rm; shift_type = t; shift_use_latch = 1'b1; carry_in = 1'b0;
    #1;
    chk({name, " shift_out"}, shift_out, exp_sh);
    chk({name, " shift_carry"}, {31'd0, shift_carry}, {31'd0, exp_c});
  endtask

  logic [7:0]  m_amt;
  logic [31:0] m_opb;
  logic [32:0] sh;
  logic [35:0] al;
  logic [31:0] opb;

  initial begin
    vecs[0]  = '{32'h0, 32'h8000000F, 4'd13, 4'h0, 2'd0, 5'd4,  1'b0, 1'b0, 32'h000000F0, 4'b0000, 32'h000000F0, 1'b0};
    vecs[1]  = '{32'h0, 32'h00000003, 4'd13, 4'h0, 2'd3, 5'd0,  1'b1, 1'b1, 32'h80000001, 4'b1010, 32'h80000001, 1'b1};
    vecs[2]  = '{32'h5, 32'h00000007, 4'd2,  4'h0, 2'd0, 5'd0,  1'b0, 1'b0, 32'hFFFFFFFE, 4'b1000, 32'h00000007, 1'b0};
    vecs[3]  = '{32'h7, 32'h00000007, 4'd10, 4'h0, 2'd0, 5'd0,  1'b0, 1'b0, 32'h00000000, 4'b0110, 32'h00000007, 1'b0};
    vecs[4]  = '{32'h7FFFFFFF, 32'h1, 4'd4, 4'h0, 2'd0, 5'd0,   1'b0, 1'b0, 32'h80000000, 4'b1001, 32'h00000001, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'h0, 4'd5, 4'h2, 2'd0, 5'd0,   1'b0, 1'b0, 32'h00000000, 4'b0110, 32'h00000000, 1'b0};
    vecs[6]  = '{32'h0, 32'h80000000, 4'd13, 4'h0, 2'd1, 5'd0,  1'b0, 1'b0, 32'h00000000, 4'b0110, 32'h00000000, 1'b1};
    vecs[7]  = '{32'h0, 32'h80000000, 4'd13, 4'h0, 2'd2, 5'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 4'b1010, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{32'hFFFF0000, 32'h12345678, 4'd0, 4'h0, 2'd3, 5'd0, 1'b0, 1'b1, 32'h12340000, 4'b0010, 32'h12345678, 1'b1};
    vecs[9]  = '{32'h0, 32'h00000001, 4'd15, 4'h1, 2'd0, 5'd31, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0001, 32'h80000000, 1'b0};
    vecs[10] = '{32'h1, 32'h00000000, 4'd3,  4'h0, 2'd0, 5'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 4'b1000, 32'h00000000, 1'b0};
    vecs[11] = '{32'h0, 32'h00000000, 4'd6,  4'h0, 2'd0, 5'd0,  1'b0, 1'b0, 32'hFFFFFFFF, 4'b1000, 32'h00000000, 1'b0};
    vecs[12] = '{32'hFF, 32'h0000000F, 4'd14, 4'h0, 2'd0, 5'd0, 1'b0, 1'b1, 32'h000000F0, 4'b0010, 32'h0000000F, 1'b1};
    vecs[13] = '{32'hAA, 32'h000000AA, 4'd9,  4'h0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h00000000, 4'b0100, 32'h000000AA, 1'b0};
    vecs[14] = '{32'h80000000, 32'h80000000, 4'd11, 4'h0, 2'd0, 5'd0, 1'b0, 1'b0, 32'h00000000, 4'b0111, 32'h80000000, 1'b0};
    vecs[15] = '{32'h0, 32'h00000005, 4'd7,  4'h2, 2'd0, 5'd0,  1'b0, 1'b0, 32'h00000005, 4'b0010, 32'h00000005, 1'b0};

    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state: both latches read back as zero.
    use_op_b_latch = 1'b1; alu_op = 4'd13; #1;
    chk("reset op_b latch", result, 32'd0);
    use_op_b_latch = 1'b0; shift_use_latch = 1'b1; shift_type = 2'd3;
    r_in = 32'h0000A5A5; carry_in = 1'b1; #1;
    chk("reset amt latch shift_out", shift_out, 32'h0000A5A5);
    chk("reset amt latch carry", {31'd0, shift_carry}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      op_a = vecs[i].a; r_in = vecs[i].rin; alu_op = vecs[i].op; flags_in = vecs[i].fin;
      shift_type = vecs[i].st; shift_amount = vecs[i].amt;
      shift_use_rxx = vecs[i].rrx; carry_in = vecs[i].cin;
      #1;
      chk($sformatf("vec%0d result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d flags", i), {28'd0, flags_out}, {28'd0, vecs[i].exp_fl});
      chk($sformatf("vec%0d shift_out", i), shift_out, vecs[i].exp_sh);
      chk($sformatf("vec%0d shift_carry", i), {31'd0, shift_carry}, {31'd0, vecs[i].exp_c});
    end

    // Register-specified shifts.
    @(negedge clk); idle();
    reg_shift("reg lsr 32", 32'h120, 2'd1, 32'h80000000, 32'h0, 1'b1);
    chk("reg lsr 32 mov result", result, 32'h0);
    reg_shift("reg lsr 33", 32'h121, 2'd1, 32'h80000000, 32'h0, 1'b0);
    reg_shift("reg lsl 32", 32'h20, 2'd0, 32'h00000001, 32'h0, 1'b1);
    reg_shift("reg lsl 40", 32'h28, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b0);
    reg_shift("reg asr 200", 32'hC8, 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    reg_shift("reg ror 64", 32'h40, 2'd3, 32'h80000001, 32'h80000001, 1'b1);
    reg_shift("reg ror 4", 32'h24, 2'd3, 32'h0000001F, 32'hF0000001, 1'b1);

    // Latch and use in the same cycle: use sees the old amount (32).
    reg_shift("reg lsr 32b", 32'h20, 2'd1, 32'h80000000, 32'h0, 1'b1);
    @(negedge clk);
    r_in = 32'h80000021; shift_latch_amt = 1'b1; #1;
    chk("same-cycle amt old carry", {31'd0, shift_carry}, 32'd1);
    @(negedge clk);
    shift_latch_amt = 1'b0; r_in = 32'h80000000; #1;
    chk("same-cycle amt new carry", {31'd0, shift_carry}, 32'd0);

    // Op-B latch, override, and reset mid-sequence.
    @(negedge clk); idle();
    r_in = 32'h1234; latch_op_b = 1'b1;
    @(negedge clk);
    latch_op_b = 1'b0; r_in = 32'hFFFF0000; use_op_b_latch = 1'b1;
    alu_op = 4'd12; op_a = 32'h1; flags_in = 4'b0010; #1;
    chk("opb latch orr result", result, 32'h1235);
    chk("opb latch orr flags", {28'd0, flags_out}, 32'h2);
    disable_op_b = 1'b1; #1;
    chk("disable overrides latch", result, 32'h1);
    disable_op_b = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("opb latch after reset", result, 32'h1);

    // Randomized run against the reference model.
    @(negedge clk); idle();
    m_amt = 8'd0; m_opb = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset           = ($urandom_range(0, 63) == 0);
      op_a            = ($urandom_range(0, 3) == 0) ? r_in : $urandom;
      r_in            = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      alu_op          = 4'($urandom);
      flags_in        = 4'($urandom);
      latch_op_b      = ($urandom_range(0, 3) == 0);
      use_op_b_latch  = ($urandom_range(0, 3) == 0);
      disable_op_b    = ($urandom_range(0, 7) == 0);
      shift_type      = 2'($urandom);
      shift_amount    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      shift_latch_amt = ($urandom_range(0, 2) == 0);
      shift_use_latch = ($urandom_range(0, 1) == 0);
      shift_use_rxx   = 1'($urandom);
      carry_in        = 1'($urandom);
      #1;
      sh  = m_shift(r_in, shift_use_latch ? m_amt : {3'b000, shift_amount},
                    shift_type, shift_use_latch, shift_use_rxx, carry_in);
      opb = disable_op_b ? 32'd0 : (use_op_b_latch ? m_opb : sh[31:0]);
      al  = m_alu(op_a, opb, alu_op, flags_in, disable_op_b | use_op_b_latch, sh[32]);
      chk("rand shift_out", shift_out, sh[31:0]);
      chk("rand shift_carry", {31'd0, shift_carry}, {31'd0, sh[32]});
      chk("rand result", result, al[31:0]);
      chk("rand flags", {28'd0, flags_out}, {28'd0, al[35:32]});
      @(posedge clk);
      if (reset) begin
        m_amt = 8'd0;
        m_opb = 32'd0;
      end else begin
        if (shift_latch_amt) m_amt = r_in[7:0];
        if (latch_op_b)      m_opb = sh[31:0];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
